branch_predict_unit: RTL and testbench

- Parametrised successor to the single-cycle branch resolver.
- Adds a direct-mapped branch target buffer with saturating direction counters, looked up at fetch.
- Resolves branches, JAL and JALR in EX and raises redirect/flush on misprediction.
- Keeps branch and misprediction performance counters; sits between the PC mux (fetch) and the EX stage.

---
 rtl/branch_predict_unit.sv | 148 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with saturating direction counters
// looked up at fetch, plus EX-stage resolution, redirect and perf counters.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] fetch_PC,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_PC,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [31:0]     ex_ALU_result,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic [31:0]     next_PC_four,
    output logic [31:0]     branch_PC,
    output logic            PC_sel,
    output logic            flush,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];

    logic [31:0] bcnt_q;
    logic [31:0] mcnt_q;

    // ---------------- fetch lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = fetch_PC[IDX_W+1:2];
    assign f_tag = fetch_PC[PC_W-1:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken  = f_hit && ctr_q[f_idx][CTR_W-1];
    assign pred_target = pred_taken ? 32'(tgt_q[f_idx])
                                    : 32'(fetch_PC) + 32'd4;

    // ---------------- EX resolve ----------------
    logic        ctl;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        mispredict;

    assign ctl          = ex_branch | ex_jal | ex_jalr;
    assign actual_taken = ex_jal | ex_jalr | (ex_branch & ex_ALU_result[0]);
    assign next_PC_four = 32'(ex_PC) + 32'd4;

    assign actual_target = ex_jalr ? {ex_ALU_result[31:1], 1'b0}
                                   : 32'(ex_PC) + ex_imm;

    // Covers non-control instructions that were predicted taken via aliasing.
    assign mispredict = ex_valid &&
        ((actual_taken != ex_pred_taken) ||
         (actual_taken && (actual_target != ex_pred_target)));

    assign PC_sel    = mispredict;
    assign flush     = mispredict;
    assign branch_PC = actual_taken ? actual_target : next_PC_four;

    // ---------------- table update decode ----------------
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic             upd_en;
    logic             do_alloc;
    logic             do_train;
    logic             do_kill;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_nxt;

    assign e_idx   = ex_PC[IDX_W+1:2];
    assign e_tag   = ex_PC[PC_W-1:IDX_W+2];
    assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign ctr_cur = ctr_q[e_idx];

    assign upd_en   = ex_valid & ctl;
    assign do_alloc = upd_en & ~e_hit & actual_taken;
    assign do_train = upd_en & e_hit;
    assign do_kill  = ex_valid & ~ctl & e_hit;

    always_comb begin
        ctr_nxt = ctr_cur;
        if (actual_taken) begin
            if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != CTR_MIN) ctr_nxt = ctr_cur - 1'b1;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WNT;
            end
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (do_alloc) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= actual_target[PC_W-1:0];
                ctr_q[e_idx]   <= CTR_WT;
            end else if (do_train) begin
                ctr_q[e_idx] <= ctr_nxt;
                if (actual_taken) tgt_q[e_idx] <= actual_target[PC_W-1:0];
            end else if (do_kill) begin
                valid_q[e_idx] <= 1'b0;
            end
            if (upd_en) begin
                bcnt_q <= bcnt_q + 32'd1;
                mcnt_q <= mcnt_q + 32'(mispredict);
            end
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

    // Instructions are word aligned; the byte offset never selects anything.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_PC[1:0], ex_PC[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expectations are queued when
// stimulus is applied and popped when the combinational outputs settle.
module tb_branch_predict_unit;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] fetch_PC;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            ex_valid;
    logic [PC_W-1:0] ex_PC;
    logic [31:0]     ex_imm;
    logic            ex_branch;
    logic            ex_jal;
    logic            ex_jalr;
    logic [31:0]     ex_ALU_result;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;
    logic [31:0]     next_PC_four;
    logic [31:0]     branch_PC;
    logic            PC_sel;
    logic            flush;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    branch_predict_unit #(.PC_W(PC_W), .ENTRIES(16), .CTR_W(2)) dut (
        .clk(clk), .reset(reset), .fetch_PC(fetch_PC),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_ALU_result(ex_ALU_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .next_PC_four(next_PC_four),
        .branch_PC(branch_PC), .PC_sel(PC_sel), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        ex_PC          = '0;
        ex_imm         = '0;
        ex_branch      = 1'b0;
        ex_jal         = 1'b0;
        ex_jalr        = 1'b0;
        ex_ALU_result  = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic jal,
                            input logic jalr, input logic [PC_W-1:0] pc,
                            input logic [31:0] imm, input logic [31:0] alu,
                            input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_branch      = br;
        ex_jal         = jal;
        ex_jalr        = jalr;
        ex_PC          = pc;
        ex_imm         = imm;
        ex_ALU_result  = alu;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        fetch_PC = 9'h040;
        reset = 1'b1;
        #12 reset = 1'b0;
        @(negedge clk);
        push("rst_pred_taken", 32'd0);
        push("rst_pred_target", 32'h44);
        push("rst_branch_count", 32'd0);
        push("rst_mispredict_count", 32'd0);
        push("rst_pc_sel", 32'd0);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
    endtask

    task automatic test_cold_branch();
        exp_t e;
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h0);
        fetch_PC = 9'h040;
        push("cold_pc_sel", 32'd1);
        push("cold_flush", 32'd1);
        push("cold_branch_pc", 32'h60);
        push("cold_next_pc_four", 32'h44);
        push("cold_no_bypass", 32'd0);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (flush !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, flush, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (next_PC_four !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, next_PC_four, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        @(negedge clk);
        idle();
        push("cold_pred_taken", 32'd1);
        push("cold_pred_target", 32'h60);
        push("cold_branch_count", 32'd1);
        push("cold_mispredict_count", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 1, 32'h60);
            push($sformatf("sat_taken%0d_pc_sel", k), 32'd0);
            #2;
            e = sb.pop_front(); n_cmp++;
            if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        end
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60);
        push("sat_nt1_pc_sel", 32'd1);
        push("sat_nt1_branch_pc", 32'h44);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        @(negedge clk);
        idle();
        push("sat_still_taken", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60);
        push("sat_nt2_pc_sel", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        @(negedge clk);
        idle();
        push("sat_now_not_taken", 32'd0);
        push("sat_fallthrough_target", 32'h44);
        push("sat_branch_count", 32'd5);
        push("sat_mispredict_count", 32'd3);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
    endtask

    task automatic test_alias();
        exp_t e;
        // retrain entry 0 (ctr 1 -> 2) so it predicts taken again
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h0);
        push("alias_retrain_pc_sel", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        @(negedge clk);
        idle();
        fetch_PC = 9'h0C0;
        push("alias_other_tag_pred", 32'd0);
        push("alias_other_tag_target", 32'hC4);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        // non-control at the other tag misses and must not disturb entry 0
        @(negedge clk);
        drive_ex(1, 0, 0, 0, 9'h0C0, 32'h0, 32'h0, 0, 32'h0);
        push("alias_miss_noncontrol_pc_sel", 32'd0);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        @(negedge clk);
        idle();
        fetch_PC = 9'h040;
        push("alias_entry_kept", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        @(negedge clk);
        drive_ex(1, 0, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60);
        push("alias_hit_pc_sel", 32'd1);
        push("alias_hit_branch_pc", 32'h44);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        @(negedge clk);
        idle();
        push("alias_invalidated", 32'd0);
        push("alias_branch_count", 32'd6);
        push("alias_mispredict_count", 32'd4);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
    endtask

    task automatic test_jalr();
        exp_t e;
        @(negedge clk);
        drive_ex(1, 0, 0, 1, 9'h100, 32'h0, 32'h123, 1, 32'h122);
        push("jalr_ok_pc_sel", 32'd0);
        push("jalr_ok_branch_pc", 32'h122);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        @(negedge clk);
        drive_ex(1, 0, 0, 1, 9'h100, 32'h0, 32'h155, 1, 32'h122);
        push("jalr_bad_pc_sel", 32'd1);
        push("jalr_bad_branch_pc", 32'h154);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        @(negedge clk);
        drive_ex(0, 0, 0, 1, 9'h100, 32'h0, 32'h155, 1, 32'h122);
        push("jalr_bubble_pc_sel", 32'd0);
        push("jalr_bubble_flush", 32'd0);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (flush !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, flush, e.v[0]); end
        @(negedge clk);
        idle();
        fetch_PC = 9'h100;
        push("jalr_branch_count", 32'd8);
        push("jalr_mispredict_count", 32'd5);
        push("jalr_pred_taken", 32'd1);
        push("jalr_pred_target", 32'h154);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
    endtask

    task automatic test_jal_and_truncation();
        exp_t e;
        @(negedge clk);
        drive_ex(1, 0, 1, 0, 9'h1F0, 32'hFFFF_FFF0, 32'h0, 0, 32'h0);
        push("jal_back_pc_sel", 32'd1);
        push("jal_back_branch_pc", 32'h1E0);
        push("jal_back_next_pc_four", 32'h1F4);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (next_PC_four !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, next_PC_four, e.v); end
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h1F8, 32'h100, 32'h1, 0, 32'h0);
        fetch_PC = 9'h1F0;
        push("jal_pred_target", 32'h1E0);
        push("wide_branch_pc", 32'h2F8);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (branch_PC !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_PC, e.v); end
        @(negedge clk);
        idle();
        fetch_PC = 9'h1F8;
        push("wide_truncated_target", 32'h0F8);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        @(negedge clk);
        drive_ex(1, 1, 0, 0, 9'h1F8, 32'h100, 32'h1, 1, 32'h0F8);
        push("wide_always_mispredicts", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (PC_sel !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, PC_sel, e.v[0]); end
        @(negedge clk);
        idle();
        push("jal_branch_count", 32'd11);
        push("jal_mispredict_count", 32'd8);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        idle();
        fetch_PC = 9'h100;
        push("prerst_hit", 32'd1);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        @(posedge clk);
        #2 reset = 1'b1;
        push("arst_pred_taken", 32'd0);
        push("arst_pred_target", 32'h104);
        push("arst_branch_count", 32'd0);
        push("arst_mispredict_count", 32'd0);
        #1;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
        e = sb.pop_front(); n_cmp++;
        if (pred_target !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_target, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (branch_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, branch_count, e.v); end
        e = sb.pop_front(); n_cmp++;
        if (mispredict_count !== e.v) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, mispredict_count, e.v); end
        #1 reset = 1'b0;
        @(negedge clk);
        push("postrst_miss", 32'd0);
        #2;
        e = sb.pop_front(); n_cmp++;
        if (pred_taken !== e.v[0]) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, pred_taken, e.v[0]); end
    endtask

    initial begin
        test_reset();
        test_cold_branch();
        test_saturation();
        test_alias();
        test_jalr();
        test_jal_and_truncation();
        test_async_reset();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
